// File: rtl/lzw_stream_encoder.sv
// rtl/lzw_stream_encoder.sv - streaming LZW encoder with valid/ready symbol input and fixed-width code output
module lzw_stream_encoder #(
    parameter int DATA_WIDTH    = 8,
    parameter int CODE_WIDTH    = 9,
    parameter bit RESET_ON_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CODE_WIDTH-1:0] out_code,
    output logic                  out_last,
    output logic                  busy,
    output logic [CODE_WIDTH-1:0] dict_count
);
    localparam int CLEAR_CODE = 2 ** DATA_WIDTH;
    localparam int FIRST_CODE = CLEAR_CODE + 1;
    localparam int MAX_CODE   = 2 ** CODE_WIDTH - 1;
    localparam int DICT_SIZE  = 2 ** CODE_WIDTH - FIRST_CODE;
    localparam int IDX_W      = $clog2(DICT_SIZE);
    localparam int ENTRY_W    = CODE_WIDTH + DATA_WIDTH;

    localparam logic [CODE_WIDTH:0]   FIRST_N = FIRST_CODE[CODE_WIDTH:0];
    localparam logic [CODE_WIDTH:0]   MAX_N   = MAX_CODE[CODE_WIDTH:0];
    localparam logic [CODE_WIDTH:0]   ONE_N   = {{CODE_WIDTH{1'b0}}, 1'b1};
    localparam logic [CODE_WIDTH-1:0] CLEAR_W = CLEAR_CODE[CODE_WIDTH-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEARCH,
        S_EMIT,
        S_EMIT_LAST,
        S_CLEAR
    } state_t;

    state_t state, state_nx;

    logic [CODE_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] c;
    logic                  c_last;
    logic [CODE_WIDTH:0]   idx;
    logic [CODE_WIDTH:0]   next_code;
    logic [ENTRY_W-1:0]    dict [DICT_SIZE];

    logic [IDX_W-1:0] rd_off;
    logic [IDX_W-1:0] wr_off;
    logic             in_hs;
    logic             out_hs;
    logic             miss;
    logic             hit;
    logic             can_insert;
    logic             becomes_full;

    assign in_ready   = (state == S_FETCH) || (state == S_IDLE && cs);
    assign out_valid  = (state == S_EMIT) || (state == S_EMIT_LAST) || (state == S_CLEAR);
    assign out_last   = (state == S_EMIT_LAST);
    assign out_code   = (state == S_CLEAR) ? CLEAR_W : (out_valid ? w : '0);
    assign busy       = (state != S_IDLE);
    assign dict_count = CODE_WIDTH'(next_code - FIRST_N);

    assign in_hs        = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;
    assign rd_off       = IDX_W'(idx - FIRST_N);
    assign wr_off       = IDX_W'(next_code - FIRST_N);
    // Entries at or beyond next_code are stale, so the scan stops there.
    assign miss         = (idx == next_code);
    assign hit          = (state == S_SEARCH) && !miss && (dict[rd_off] == {w, c});
    assign can_insert   = (next_code <= MAX_N);
    assign becomes_full = (next_code == MAX_N);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (in_hs) state_nx = in_last ? S_EMIT_LAST : S_FETCH;
            end
            S_FETCH: begin
                if (in_hs) state_nx = S_SEARCH;
            end
            S_SEARCH: begin
                if (miss) state_nx = S_EMIT;
                else if (hit) state_nx = c_last ? S_EMIT_LAST : S_FETCH;
            end
            S_EMIT: begin
                if (out_hs) begin
                    if (RESET_ON_FULL && becomes_full) state_nx = S_CLEAR;
                    else state_nx = c_last ? S_EMIT_LAST : S_FETCH;
                end
            end
            S_CLEAR: begin
                if (out_hs) state_nx = c_last ? S_EMIT_LAST : S_FETCH;
            end
            S_EMIT_LAST: begin
                if (out_hs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w         <= '0;
            c         <= '0;
            c_last    <= 1'b0;
            idx       <= '0;
            next_code <= FIRST_N;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_hs) w <= CODE_WIDTH'(in_data);
                end
                S_FETCH: begin
                    if (in_hs) begin
                        c      <= in_data;
                        c_last <= in_last;
                        idx    <= FIRST_N;
                    end
                end
                S_SEARCH: begin
                    if (hit) w <= idx[CODE_WIDTH-1:0];
                    else if (!miss) idx <= idx + ONE_N;
                end
                S_EMIT: begin
                    if (out_hs) begin
                        if (can_insert) next_code <= next_code + ONE_N;
                        w <= CODE_WIDTH'(c);
                    end
                end
                S_CLEAR, S_EMIT_LAST: begin
                    if (out_hs) next_code <= FIRST_N;
                end
                default: ;
            endcase
        end
    end

    // Contents need no reset: validity comes from next_code alone.
    always_ff @(posedge clk) begin
        if (state == S_EMIT && out_hs && can_insert) begin
            dict[wr_off] <= {w, c};
        end
    end
endmodule

// File: tb/tb_lzw_stream_encoder.sv
// tb/tb_lzw_stream_encoder.sv - scoreboard bench for lzw_stream_encoder against a dictionary-based LZW model
module tb_lzw_stream_encoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_drv;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;
    logic       sel;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [8:0] a_out_code, a_dict_count;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [8:0] b_out_code, b_dict_count;

    logic       mon_in_ready, mon_valid, mon_last, mon_busy;
    logic [8:0] mon_code, mon_dict_count;

    int exp_q[$];
    int total = 0;
    int bad = 0;
    int rdy_mode = 0;
    bit stall = 0;
    int hold_code = 0;
    int hold_last = 0;

    always #5 clk = ~clk;

    lzw_stream_encoder #(.DATA_WIDTH(8), .CODE_WIDTH(9), .RESET_ON_FULL(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .cs(cs_drv && !sel),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_code(a_out_code), .out_last(a_out_last),
        .busy(a_busy), .dict_count(a_dict_count)
    );

    lzw_stream_encoder #(.DATA_WIDTH(8), .CODE_WIDTH(9), .RESET_ON_FULL(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .cs(cs_drv && sel),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_code(b_out_code), .out_last(b_out_last),
        .busy(b_busy), .dict_count(b_dict_count)
    );

    assign mon_in_ready   = sel ? b_in_ready   : a_in_ready;
    assign mon_valid      = sel ? b_out_valid  : a_out_valid;
    assign mon_last       = sel ? b_out_last   : a_out_last;
    assign mon_busy       = sel ? b_busy       : a_busy;
    assign mon_code       = sel ? b_out_code   : a_out_code;
    assign mon_dict_count = sel ? b_dict_count : a_dict_count;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: classic LZW over an associative map keyed by (prefix, char).
    function automatic void model(input int s[$], input bit reset_on_full);
        int dict[int];
        int w, c, nxt, key;
        w = s[0];
        nxt = 257;
        for (int i = 1; i < s.size(); i++) begin
            c = s[i];
            key = w * 256 + c;
            if (dict.exists(key)) begin
                w = dict[key];
            end else begin
                exp_q.push_back(w);
                if (nxt <= 511) begin
                    dict[key] = nxt;
                    nxt++;
                end
                if (reset_on_full && nxt == 512) begin
                    exp_q.push_back(256);
                    dict.delete();
                    nxt = 257;
                end
                w = c;
            end
        end
        exp_q.push_back(w | (1 << 16));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", mon_valid, 1);
                chk("hold_code", mon_code, hold_code);
                chk("hold_last", mon_last, hold_last);
            end
            if (mon_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_code: got %0d expected none", mon_code);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("code", mon_code, e & 16'hFFFF);
                    chk("last", mon_last, e >> 16);
                end
            end
            stall = mon_valid && !out_ready;
            hold_code = mon_code;
            hold_last = mon_last;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_sym(input int d, input bit l);
        int t = 0;
        in_valid = 1'b1;
        in_data = d[7:0];
        in_last = l;
        do begin
            @(negedge clk);
            t++;
        end while (!mon_in_ready && t < 2000);
        if (!mon_in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cs_drv = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || mon_busy) && t < 5000);
        if (t >= 5000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input int s[$], input bit gaps);
        model(s, !sel);
        cs_drv = 1'b1;
        for (int i = 0; i < s.size(); i++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sym(s[i], i == s.size() - 1);
        end
        wait_idle();
    endtask

    task automatic wait_out(input int code, input int last, input string nm);
        int t = 0;
        while (!(mon_valid && mon_code == code && mon_last == last) && t < 40000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 40000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got none expected code %0d", nm, code);
        end
    endtask

    initial begin
        int s1[$];
        int sf[$];
        int sr[$];
        s1 = '{65, 66, 65, 66, 65, 66, 65};
        for (int i = 0; i < 256; i++) sf.push_back(i);
        sf.push_back(0);

        sel = 1'b0;
        rst_n = 1'b0;
        cs_drv = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", a_out_valid | b_out_valid, 0);
        chk("rst_out_last", a_out_last | b_out_last, 0);
        chk("rst_out_code", a_out_code | b_out_code, 0);
        chk("rst_busy", a_busy | b_busy, 0);
        chk("rst_dict_count", a_dict_count | b_dict_count, 0);
        chk("rst_in_ready", a_in_ready | b_in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fork
            send_stream(s1, 1'b0);
            begin
                wait_out(259, 1, "s1_final");
                chk("s1_dict_before_last", mon_dict_count, 3);
            end
        join
        chk("s1_busy_after", mon_busy, 0);
        chk("s1_dict_after", mon_dict_count, 0);

        fork
            send_stream('{127}, 1'b0);
            begin
                wait_out(127, 1, "single");
                chk("single_dict", mon_dict_count, 0);
            end
        join
        chk("single_dict_after", mon_dict_count, 0);

        rdy_mode = 2;
        out_ready = 1'b0;
        fork
            send_stream(s1, 1'b0);
            begin
                wait_out(65, 0, "bp_first");
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                wait_out(66, 0, "bp_pending");
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", mon_valid, 1);
                    chk("bp_code", mon_code, 66);
                    chk("bp_in_ready", mon_in_ready, 0);
                end
                @(posedge clk);
                #1;
                rdy_mode = 0;
                out_ready = 1'b1;
            end
        join

        rdy_mode = 0;
        cs_drv = 1'b1;
        send_sym(65, 1'b0);
        send_sym(66, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", mon_valid, 0);
        chk("mid_rst_in_ready", mon_in_ready, 0);
        chk("mid_rst_busy", mon_busy, 0);
        chk("mid_rst_dict", mon_dict_count, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        send_stream(s1, 1'b0);

        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            rdy_mode = 1;
            repeat (15) begin
                int n;
                n = $urandom_range(1, 30);
                sr.delete();
                for (int i = 0; i < n; i++) sr.push_back($urandom_range(0, 3));
                send_stream(sr, 1'b1);
            end
        end

        rdy_mode = 0;
        sel = 1'b0;
        fork
            send_stream(sf, 1'b0);
            begin
                wait_out(256, 0, "full_clear");
                chk("full_dict_before_clear", mon_dict_count, 255);
                wait_out(255, 0, "full_after_clear");
                chk("full_dict_after_clear", mon_dict_count, 0);
            end
        join

        sel = 1'b1;
        fork
            send_stream(sf, 1'b0);
            begin
                wait_out(0, 1, "freeze_last");
                chk("freeze_dict_sat", mon_dict_count, 255);
            end
        join
        chk("freeze_dict_after", mon_dict_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
